// File: rtl/accel_dma_pkg.sv
// accel_dma_pkg
// Shared definitions for the accelerator read and write DMAs.
//   - dma_state_e : controller state encoding (IDLE / ACTIVE / DRAIN)
//   - DMA_LANE_W  : byte-lane index width for the default 128-bit line
//   - dma_desc_t  : descriptor {addr, len} as written by the command registers
package accel_dma_pkg;

   localparam int DMA_DATA_WIDTH = 128;
   localparam int DMA_STRB_WIDTH = DMA_DATA_WIDTH / 8;
   localparam int DMA_LANE_W     = $clog2(DMA_STRB_WIDTH);
   localparam int DMA_ADDR_WIDTH = 16;
   localparam int DMA_LEN_WIDTH  = 14;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DRAIN  = 2'd2
   } dma_state_e;

   typedef struct packed {
      logic [DMA_ADDR_WIDTH-1:0] addr;
      logic [DMA_LEN_WIDTH-1:0]  len;
   } dma_desc_t;

endpackage

// File: rtl/wr_line_packer.sv
// wr_line_packer
// Byte-to-line accumulation buffer for the write DMA.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   byte_data      incoming byte
//   byte_valid     byte accepted this cycle
//   flush          this accepted byte closes the line (buffer emptied, lane -> 0)
//   clear          start of a descriptor: empty buffer, load clear_lane
//   clear_lane     starting lane taken from the low byte-address bits
//   lane           lane the next byte will occupy
//   line_data      buffer contents with the current byte merged in
//   line_strb      strobes with the current byte's lane merged in
module wr_line_packer #(
   parameter int DATA_WIDTH = 128,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int LANE_W     = $clog2(STRB_WIDTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            byte_data,
   input  logic                  byte_valid,
   input  logic                  flush,
   input  logic                  clear,
   input  logic [LANE_W-1:0]     clear_lane,
   output logic [LANE_W-1:0]     lane,
   output logic [DATA_WIDTH-1:0] line_data,
   output logic [STRB_WIDTH-1:0] line_strb
);

   logic [DATA_WIDTH-1:0] buf_reg;
   logic [STRB_WIDTH-1:0] strb_reg;
   logic [LANE_W-1:0]     lane_reg;
   logic [STRB_WIDTH-1:0] lane_hit;

   // The merged view lets the top capture a line in the same cycle as the
   // byte that completes it, so line boundaries cost no bubble.
   generate
      for (genvar gi = 0; gi < STRB_WIDTH; gi++) begin : g_lane
         assign lane_hit[gi]          = byte_valid && (lane_reg == LANE_W'(gi));
         assign line_data[gi*8 +: 8] = lane_hit[gi] ? byte_data : buf_reg[gi*8 +: 8];
         assign line_strb[gi]         = lane_hit[gi] | strb_reg[gi];
      end
   endgenerate

   assign lane = lane_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         buf_reg  <= '0;
         strb_reg <= '0;
         lane_reg <= '0;
      end else if (clear) begin
         buf_reg  <= '0;
         strb_reg <= '0;
         lane_reg <= clear_lane;
      end else if (byte_valid) begin
         if (flush) begin
            buf_reg  <= '0;
            strb_reg <= '0;
            lane_reg <= '0;
         end else begin
            buf_reg  <= line_data;
            strb_reg <= line_strb;
            lane_reg <= lane_reg + 1'b1;
         end
      end
   end

endmodule

// File: rtl/accel_wr_dma_sp.sv
// accel_wr_dma_sp
// Single-port write DMA: packs a byte-wide stream into DATA_WIDTH lines of one
// packet-memory block starting at any byte address.
// Optional feature macro: ACCEL_WR_DMA_DRAIN_EN -- when defined, bytes left in
// the stream after the descriptor length is exhausted are consumed and dropped
// up to tlast (DRAIN state). When undefined they stay in the stream.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   desc_addr/len/valid, desc_ready   descriptor (accepted in IDLE only)
//   s_axis_tdata/tlast/tvalid/tready  byte stream input
//   mem_wr_en/strb/addr/data      registered line write to the memory block
//   busy                          controller not idle
//   done, done_len, short_pkt     completion pulse, byte count, early-tlast flag
module accel_wr_dma_sp
   import accel_dma_pkg::*;
#(
   parameter int DATA_WIDTH      = 128,
   parameter int STRB_WIDTH      = DATA_WIDTH / 8,
   parameter int ADDR_WIDTH      = 16,
   parameter int LINE_ADDR_WIDTH = ADDR_WIDTH - $clog2(STRB_WIDTH),
   parameter int LEN_WIDTH       = 14
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [ADDR_WIDTH-1:0]      desc_addr,
   input  logic [LEN_WIDTH-1:0]       desc_len,
   input  logic                       desc_valid,
   output logic                       desc_ready,
   input  logic [7:0]                 s_axis_tdata,
   input  logic                       s_axis_tlast,
   input  logic                       s_axis_tvalid,
   output logic                       s_axis_tready,
   output logic                       mem_wr_en,
   output logic [STRB_WIDTH-1:0]      mem_wr_strb,
   output logic [LINE_ADDR_WIDTH-1:0] mem_wr_addr,
   output logic [DATA_WIDTH-1:0]      mem_wr_data,
   output logic                       busy,
   output logic                       done,
   output logic [LEN_WIDTH-1:0]       done_len,
   output logic                       short_pkt
);

   localparam int LANE_W = $clog2(STRB_WIDTH);

   dma_state_e                 state_reg, state_next;
   logic [LINE_ADDR_WIDTH-1:0] line_ptr_reg;
   logic [LEN_WIDTH-1:0]       count_reg, len_reg, count_inc;
   logic                       accept, len_hit, flush, desc_take;
   logic [LANE_W-1:0]          cur_lane;
   logic [DATA_WIDTH-1:0]      line_data;
   logic [STRB_WIDTH-1:0]      line_strb;

   logic                       mem_wr_en_reg;
   logic [STRB_WIDTH-1:0]      mem_wr_strb_reg;
   logic [LINE_ADDR_WIDTH-1:0] mem_wr_addr_reg;
   logic [DATA_WIDTH-1:0]      mem_wr_data_reg;
   logic                       done_reg, short_pkt_reg;
   logic [LEN_WIDTH-1:0]       done_len_reg;

   wr_line_packer #(
      .DATA_WIDTH (DATA_WIDTH),
      .STRB_WIDTH (STRB_WIDTH),
      .LANE_W     (LANE_W)
   ) u_packer (
      .clk        (clk),
      .rst        (rst),
      .byte_data  (s_axis_tdata),
      .byte_valid (accept),
      .flush      (flush),
      .clear      (desc_take),
      .clear_lane (desc_addr[LANE_W-1:0]),
      .lane       (cur_lane),
      .line_data  (line_data),
      .line_strb  (line_strb)
   );

   always_comb begin
      state_next    = state_reg;
      desc_ready    = 1'b0;
      s_axis_tready = 1'b0;
      busy          = 1'b1;
      desc_take     = 1'b0;
      accept        = 1'b0;
      flush         = 1'b0;
      count_inc     = count_reg + 1'b1;
      len_hit       = (count_inc == len_reg);
      case (state_reg)
         ST_IDLE: begin
            desc_ready = 1'b1;
            busy       = 1'b0;
            if (desc_valid) begin
               desc_take = 1'b1;
               if (desc_len != '0) begin
                  state_next = ST_ACTIVE;
               end
            end
         end
         ST_ACTIVE: begin
            s_axis_tready = 1'b1;
            accept        = s_axis_tvalid;
            flush         = accept && ((cur_lane == LANE_W'(STRB_WIDTH-1)) || len_hit || s_axis_tlast);
            if (accept && len_hit) begin
`ifdef ACCEL_WR_DMA_DRAIN_EN
               state_next = s_axis_tlast ? ST_IDLE : ST_DRAIN;
`else
               state_next = ST_IDLE;
`endif
            end else if (accept && s_axis_tlast) begin
               state_next = ST_IDLE;
            end
         end
`ifdef ACCEL_WR_DMA_DRAIN_EN
         ST_DRAIN: begin
            // Leftover bytes are swallowed; completion was already reported.
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) begin
               state_next = ST_IDLE;
            end
         end
`endif
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= ST_IDLE;
         line_ptr_reg    <= '0;
         count_reg       <= '0;
         len_reg         <= '0;
         mem_wr_en_reg   <= 1'b0;
         mem_wr_strb_reg <= '0;
         mem_wr_addr_reg <= '0;
         mem_wr_data_reg <= '0;
         done_reg        <= 1'b0;
         done_len_reg    <= '0;
         short_pkt_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         mem_wr_en_reg <= 1'b0;
         done_reg      <= 1'b0;
         if (desc_take) begin
            line_ptr_reg <= desc_addr[ADDR_WIDTH-1:LANE_W];
            len_reg      <= desc_len;
            count_reg    <= '0;
            if (desc_len == '0) begin
               done_reg      <= 1'b1;
               done_len_reg  <= '0;
               short_pkt_reg <= 1'b0;
            end
         end
         if (accept) begin
            count_reg <= count_inc;
            if (flush) begin
               mem_wr_en_reg   <= 1'b1;
               mem_wr_strb_reg <= line_strb;
               mem_wr_data_reg <= line_data;
               mem_wr_addr_reg <= line_ptr_reg;
               line_ptr_reg    <= line_ptr_reg + 1'b1;
            end
            // Length exhaustion wins over a coincident tlast.
            if (len_hit) begin
               done_reg      <= 1'b1;
               done_len_reg  <= len_reg;
               short_pkt_reg <= 1'b0;
            end else if (s_axis_tlast) begin
               done_reg      <= 1'b1;
               done_len_reg  <= count_inc;
               short_pkt_reg <= 1'b1;
            end
         end
      end
   end

   assign mem_wr_en   = mem_wr_en_reg;
   assign mem_wr_strb = mem_wr_strb_reg;
   assign mem_wr_addr = mem_wr_addr_reg;
   assign mem_wr_data = mem_wr_data_reg;
   assign done        = done_reg;
   assign done_len    = done_len_reg;
   assign short_pkt   = short_pkt_reg;

endmodule

// File: tb/tb_accel_wr_dma_sp.sv
// tb_accel_wr_dma_sp
// Scoreboard bench for accel_wr_dma_sp: each packet's expected line writes and
// completion are pushed when the packet is driven and popped by a monitor
// when the DUT writes or signals done.
module tb_accel_wr_dma_sp;

   logic         clk = 1'b0;
   logic         rst;
   logic [15:0]  desc_addr;
   logic [13:0]  desc_len;
   logic         desc_valid;
   logic         desc_ready;
   logic [7:0]   s_axis_tdata;
   logic         s_axis_tlast;
   logic         s_axis_tvalid;
   logic         s_axis_tready;
   logic         mem_wr_en;
   logic [15:0]  mem_wr_strb;
   logic [11:0]  mem_wr_addr;
   logic [127:0] mem_wr_data;
   logic         busy;
   logic         done;
   logic [13:0]  done_len;
   logic         short_pkt;

   always #5 clk = ~clk;

   accel_wr_dma_sp dut (
      .clk           (clk),
      .rst           (rst),
      .desc_addr     (desc_addr),
      .desc_len      (desc_len),
      .desc_valid    (desc_valid),
      .desc_ready    (desc_ready),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .mem_wr_en     (mem_wr_en),
      .mem_wr_strb   (mem_wr_strb),
      .mem_wr_addr   (mem_wr_addr),
      .mem_wr_data   (mem_wr_data),
      .busy          (busy),
      .done          (done),
      .done_len      (done_len),
      .short_pkt     (short_pkt)
   );

   typedef struct {
      logic [11:0]  addr;
      logic [15:0]  strb;
      logic [127:0] data;
   } exp_wr_t;

   typedef struct {
      logic [13:0] len;
      logic        short_f;
   } exp_done_t;

   exp_wr_t   exp_wr[$];
   exp_done_t exp_done[$];

   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor: compare every write and every done pulse against the scoreboard.
   always @(negedge clk) begin
      if (!rst && mem_wr_en) begin
         if (exp_wr.size() == 0) begin
            check("unexpected_wr", 1'b1, 1'b0);
         end else begin
            exp_wr_t e;
            e = exp_wr.pop_front();
            check("wr_addr", mem_wr_addr, e.addr);
            check("wr_strb", mem_wr_strb, e.strb);
            check("wr_data", mem_wr_data, e.data);
            $display("wr  addr=%03h strb=%04h data=%032h", mem_wr_addr, mem_wr_strb, mem_wr_data);
         end
      end
      if (!rst && done) begin
         if (exp_done.size() == 0) begin
            check("unexpected_done", 1'b1, 1'b0);
         end else begin
            exp_done_t d;
            d = exp_done.pop_front();
            check("done_len", done_len, d.len);
            check("short_pkt", short_pkt, d.short_f);
            check("done_with_wr", mem_wr_en, d.len != 0);
            $display("done len=%0d short=%0b", done_len, short_pkt);
         end
      end
   end

   // Reference packing: lane/line walk of the accepted bytes.
   task automatic model(input logic [15:0] addr, input int len, input int tlast_pos,
                        input logic [7:0] base, output int consumed);
      int           lane;
      logic [11:0]  line;
      logic [127:0] d;
      logic [15:0]  s;
      logic         sh;
      exp_wr_t      w;
      exp_done_t    dn;
      sh       = (tlast_pos >= 0) && (tlast_pos + 1 < len);
      consumed = sh ? tlast_pos + 1 : len;
      lane     = int'(addr[3:0]);
      line     = addr[15:4];
      d        = '0;
      s        = '0;
      for (int i = 0; i < consumed; i++) begin
         d[lane*8 +: 8] = base + 8'(i);
         s[lane]        = 1'b1;
         if (lane == 15 || i == consumed - 1) begin
            w.addr = line; w.strb = s; w.data = d;
            exp_wr.push_back(w);
            d = '0; s = '0; lane = 0; line = line + 12'd1;
         end else begin
            lane++;
         end
      end
      dn.len     = 14'(consumed);
      dn.short_f = sh;
      exp_done.push_back(dn);
   endtask

   task automatic wait_ready_desc();
      int t = 0;
      while (!desc_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) check("desc_ready_timeout", 1'b0, 1'b1);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      int t = 0;
      s_axis_tdata  = b;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      while (!s_axis_tready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) check("tready_timeout", 1'b0, 1'b1);
      @(negedge clk);
   endtask

   task automatic run_pkt(input logic [15:0] addr, input int len, input int tlast_pos,
                          input logic [7:0] base, input int stream_len);
      int consumed;
      int n_drive;
      model(addr, len, tlast_pos, base, consumed);
`ifdef ACCEL_WR_DMA_DRAIN_EN
      n_drive = (len == 0) ? 0 : stream_len;
`else
      n_drive = (len == 0) ? 0 : consumed;
`endif
      wait_ready_desc();
      desc_addr  = addr;
      desc_len   = 14'(len);
      desc_valid = 1'b1;
      @(negedge clk);
      desc_valid = 1'b0;
      for (int i = 0; i < n_drive; i++) begin
         send_byte(base + 8'(i), i == tlast_pos);
      end
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      check("desc_ready_ret", desc_ready, 1'b1);
      check("tready_idle", s_axis_tready, 1'b0);
      repeat (3) @(negedge clk);
      check("wr_queue_empty", 128'(exp_wr.size()), 128'd0);
      check("done_queue_empty", 128'(exp_done.size()), 128'd0);
      $display("pkt addr=%04h len=%0d stream=%0d consumed=%0d", addr, len, stream_len, consumed);
   endtask

   initial begin
      rst           = 1'b1;
      desc_addr     = '0;
      desc_len      = '0;
      desc_valid    = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_wr_en", mem_wr_en, 1'b0);
      check("rst_wr_strb", mem_wr_strb, 16'h0);
      check("rst_wr_addr", mem_wr_addr, 12'h0);
      check("rst_wr_data", mem_wr_data, 128'h0);
      check("rst_done", done, 1'b0);
      check("rst_done_len", done_len, 14'h0);
      check("rst_short", short_pkt, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_tready", s_axis_tready, 1'b0);
      check("rst_desc_ready", desc_ready, 1'b1);

      run_pkt(16'h0020, 16, 15, 8'h00, 16);   // one aligned full line
      run_pkt(16'h001D, 5, 4, 8'hA0, 5);      // straddles two lines
      run_pkt(16'h0000, 40, 10, 8'h30, 11);   // early tlast
      run_pkt(16'h0000, 4, 7, 8'h50, 8);      // length before tlast
      run_pkt(16'hFFF8, 16, 15, 8'h70, 16);   // line pointer wrap
      run_pkt(16'h0103, 40, 39, 8'h90, 40);   // three lines back to back
      run_pkt(16'h0040, 0, -1, 8'h00, 0);     // zero length

      // Reset mid-transfer: no write, no done, clean restart.
      wait_ready_desc();
      desc_addr  = 16'h0040;
      desc_len   = 14'd16;
      desc_valid = 1'b1;
      @(negedge clk);
      desc_valid = 1'b0;
      for (int i = 0; i < 7; i++) send_byte(8'hC0 + 8'(i), 1'b0);
      s_axis_tvalid = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rstmid_desc_ready", desc_ready, 1'b1);
      check("rstmid_busy", busy, 1'b0);
      check("rstmid_wr_en", mem_wr_en, 1'b0);
      check("rstmid_done", done, 1'b0);
      $display("mid-transfer reset applied");
      run_pkt(16'h0045, 16, 15, 8'hE0, 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/accel_wr_dma_sp.md
# accel_wr_dma_sp

Single-port write DMA that packs a byte-wide AXI-stream produced by an accelerator into DATA_WIDTH-wide lines of one accelerator packet-memory block, starting at any byte address. It is the write-direction counterpart to the accelerator read DMA. It sits in the accelerator wrapper between a result-producing accelerator and the `acc_*_b1` port of the attached memory block. It is controlled by the same command-register style: the descriptor supplies address and length.

## Interface
- DATA_WIDTH, 128, memory line width in bits
- STRB_WIDTH, DATA_WIDTH/8, byte lanes per line
- ADDR_WIDTH, 16, byte address width into the block
- LINE_ADDR_WIDTH, ADDR_WIDTH-$clog2(STRB_WIDTH), memory line address width
- LEN_WIDTH, 14, descriptor length width in bytes
---
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- desc_addr  in  ADDR_WIDTH  start byte address
- desc_len  in  LEN_WIDTH  maximum bytes to write
- desc_valid  in  1  descriptor strobe
- desc_ready  out  1  high in IDLE only
- s_axis_tdata  in  8  input byte
- s_axis_tlast  in  1  last byte of the accelerator stream
- s_axis_tvalid  in  1  byte valid
- s_axis_tready  out  1  byte accepted when valid&ready
- mem_wr_en  out  1  line write strobe
- mem_wr_strb  out  STRB_WIDTH  byte enables
- mem_wr_addr  out  LINE_ADDR_WIDTH  line address
- mem_wr_data  out  DATA_WIDTH  line data; byte k at bits [8k+7:8k]
- busy  out  1  not IDLE
- done  out  1  one-cycle completion pulse
- done_len  out  LEN_WIDTH  bytes actually written, valid with done
- short_pkt  out  1  with done: tlast arrived before desc_len bytes

## Operation
- States: IDLE, ACTIVE, DRAIN (DRAIN only with macro).
- IDLE: desc_ready=1. On desc_valid, latch the line pointer desc_addr[ADDR_WIDTH-1:$clog2(STRB_WIDTH)] and the lane desc_addr[$clog2(STRB_WIDTH)-1:0]. Clear the byte count and the accumulation buffer and strobes.
  - desc_len==0 → stay IDLE; pulse done next cycle with done_len=0 and short_pkt=0. No bytes consumed.
  - Otherwise → ACTIVE.
- ACTIVE: s_axis_tready=1. Each accepted byte goes to buffer lane `lane` and sets strobe bit `lane`. Then lane increments and count increments.
- Line flush happens when the accepted byte occupies lane STRB_WIDTH-1, or count+1==desc_len, or tlast. On flush:
  - Buffer and strobes are copied to the mem_wr_* output registers.
  - The buffer is cleared, lane goes to 0, and the line pointer increments, wrapping modulo 2^LINE_ADDR_WIDTH.
- Termination (the same cycle the final flush is captured):
  - count+1==desc_len → done_len=desc_len. Next state is DRAIN if tlast=0 and the macro is set, else IDLE. short_pkt=0.
  - tlast before the length is reached → done_len=count+1, short_pkt=1, next state IDLE.
  - Both conditions in the same byte → normal completion, short_pkt=0.
- DRAIN: s_axis_tready=1 and bytes are discarded with no writes. Return to IDLE on accepted tlast; done has already pulsed.
- Byte count arithmetic is LEN_WIDTH wide; count never exceeds desc_len.
- New descriptors are ignored while busy.

## Timing
- Full throughput: 1 byte/cycle, no bubbles across line boundaries.
- Write latency: mem_wr_en is asserted the cycle after the flush-triggering byte is accepted. It is held for 1 cycle; the memory has no backpressure.
- done, done_len and short_pkt are registered and coincide with the final mem_wr_en. For desc_len==0 they come 1 cycle after desc_valid.
- desc_ready returns high the cycle after the final byte (or after tlast in DRAIN).
- Reset values: mem_wr_en=0, mem_wr_strb=0, mem_wr_addr=0, mem_wr_data=0, done=0, done_len=0, short_pkt=0, busy=0, s_axis_tready=0, desc_ready=1 the cycle after reset. State goes to IDLE.
- Reset mid-transfer discards the partial line; no flush is written.

## Configuration
- ACCEL_WR_DMA_DRAIN_EN defined: on length exhaustion, the remaining bytes up to tlast are consumed and dropped in DRAIN.
- ACCEL_WR_DMA_DRAIN_EN not defined: DRAIN state does not exist. The block goes to IDLE with tready=0, and leftover bytes remain in the stream for the next descriptor.

## Structure
- Shared package accel_dma_pkg holds:
  - the state enum (IDLE/ACTIVE/DRAIN)
  - the lane-index width constant $clog2(STRB_WIDTH)
  - the descriptor struct {addr, len}, shared with the read DMA
- One sub-module, wr_line_packer, holds the byte-to-line buffer, strobes and lane counter. Its inputs are byte, valid, flush and clear; its outputs are the line and strobe. The FSM, counters and memory output registers stay in the top.

## Test plan
- desc_addr=0x0020, len=16, 16 bytes 0x00..0x0F, tlast on byte 15 → one write: addr 0x002, strb 0xFFFF, data bytes 0x00..0x0F; done_len=16, short_pkt=0.
- desc_addr=0x001D, len=5, bytes A0..A4 → write addr 0x001, strb 0xE000, lanes 13–15=A0..A2; then write addr 0x002, strb 0x0003 with A3,A4 on consecutive cycles; done_len=5.
- len=40, tlast on byte 10, addr 0 → one write strb 0x07FF; done_len=11, short_pkt=1.
- len=4, 8-byte stream with tlast on byte 8 → one write strb 0x000F, done_len=4. With the macro, all 8 bytes are accepted and desc_ready returns after byte 8. Without it, tready=0 after byte 4.
- desc_addr=0xFFF8, len=16 → writes to line 0xFFF (strb 0xFF00) then line 0x000 (strb 0x00FF); pointer wraps.
- Assert rst after 7 of 16 bytes → no mem_wr_en, no done; after reset desc_ready=1 and a new descriptor completes normally.
